// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) serving the EX stage; result = {remainder, quotient}.
// Define DIV_BYZERO_FAST_EN to short-cut a zero divisor through the BYZERO state.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

`ifdef DIV_BYZERO_FAST_EN
    typedef enum logic [1:0] {FREE = 2'd0, BYZERO = 2'd1, ON = 2'd2, END = 2'd3} state_t;
`else
    typedef enum logic [1:0] {FREE = 2'd0, ON = 2'd2, END = 2'd3} state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               neg_quot_q, neg_quot_d;
    logic               neg_rem_q, neg_rem_d;
    logic               ready_q, ready_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     upper_ext, diff;
    logic [WIDTH-1:0]   iter_rem, iter_quot;

    // Magnitudes of the operands; negation only applies to signed divides.
    assign mag_a = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign mag_b = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // Upper half after the left shift is {rem, quot_msb}, which needs WIDTH+1 bits.
    assign upper_ext = work_q[2*WIDTH-1:WIDTH-1];
    assign diff      = upper_ext - {1'b0, divisor_q};
    assign iter_rem  = diff[WIDTH] ? upper_ext[WIDTH-1:0] : diff[WIDTH-1:0];
    assign iter_quot = {work_q[WIDTH-2:0], ~diff[WIDTH]};

    // NOTE: every variable below gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        ready_d    = ready_q;
        result_d   = result_q;

        case (state_q)
            FREE: begin
                if (start_i && !annul_i) begin
                    neg_quot_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_rem_d  = signed_div_i && opdata1_i[WIDTH-1];
                    divisor_d  = mag_b;
                    work_d     = {{WIDTH{1'b0}}, mag_a};
                    cnt_d      = '0;
`ifdef DIV_BYZERO_FAST_EN
                    state_d    = (opdata2_i == '0) ? BYZERO : ON;
`else
                    state_d    = ON;
`endif
                end
            end
`ifdef DIV_BYZERO_FAST_EN
            BYZERO: begin
                if (annul_i) begin
                    state_d = FREE;
                end else begin
                    work_d  = '0;
                    state_d = END;
                end
            end
`endif
            ON: begin
                if (annul_i) begin
                    state_d = FREE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        work_d  = {neg_rem_q ? -iter_rem : iter_rem,
                                   neg_quot_q ? -iter_quot : iter_quot};
                        state_d = END;
                    end else begin
                        work_d = {iter_rem, iter_quot};
                    end
                end
            end
            END: begin
                if (start_i) begin
                    ready_d  = 1'b1;
                    result_d = work_q;
                end else begin
                    ready_d  = 1'b0;
                    result_d = '0;
                    state_d  = FREE;
                end
            end
            default: state_d = FREE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FREE;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            ready_q    <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            ready_q    <= ready_d;
            result_q   <= result_d;
        end
    end

`ifdef DIV_BYZERO_FAST_EN
    assign busy_o = (state_q == ON) || (state_q == BYZERO);
`else
    assign busy_o = (state_q == ON);
`endif
    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed fix-up, zero divisor, annul and mid-divide reset.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic        start_i, annul_i;
    logic [63:0] result_o;
    logic        ready_o, busy_o;

    int total = 0;
    int bad   = 0;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start a divide, hold start until ready, check latency and result, then drop start.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat, input logic [31:0] exp_q,
                           input logic [31:0] exp_r);
        int e;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        e = 0;
        do begin
            @(posedge clk);
            #1;
            e++;
        end while (!ready_o && e < 60);
        check({tag, " latency"}, 64'(e), 64'(exp_lat));
        check({tag, " result"}, result_o, {exp_r, exp_q});
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " ready drop"}, 64'(ready_o), 64'd0);
        check({tag, " result drop"}, result_o, 64'd0);
    endtask

    initial begin
        int hits;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
        check("reset busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2);
        run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);
        run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
        run_div("divu big/16", 1'b0, 32'hFFFF_FFFF, 32'd16, 33, 32'h0FFF_FFFF, 32'd15);

        // Annul at iteration 10.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        check("annul busy before", 64'(busy_o), 64'd1);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("annul busy", 64'(busy_o), 64'd0);
        check("annul ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        hits    = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) hits++;
        end
        check("annul no ready", 64'(hits), 64'd0);
        run_div("divu 9/3", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0);

`ifdef DIV_BYZERO_FAST_EN
        run_div("divu 5/0", 1'b0, 32'd5, 32'd0, 2, 32'd0, 32'd0);
`else
        run_div("divu 5/0", 1'b0, 32'd5, 32'd0, 33, 32'hFFFF_FFFF, 32'd5);
`endif

        // Reset at iteration 20.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd77;
        opdata2_i    = 32'd5;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst mid ready", 64'(ready_o), 64'd0);
        check("rst mid result", result_o, 64'd0);
        check("rst mid busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        start_i = 1'b0;
        run_div("divu 10/3", 1'b0, 32'd10, 32'd3, 33, 32'd3, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
